// File: rtl/lsu_pkg.sv
// Purpose: shared funct3 codes, FSM state type and bus constants for the LSU.
// Latency: none, declarations only.
// Backpressure: n/a.
package lsu_pkg;

  // RV32I load/store width encodings (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // byte-enable width of the word-wide data bus
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Purpose: store lane replication / byte enables, load lane select + extension, misalign/illegal detect.
// Latency: purely combinational.
// Backpressure: none; caller decides when outputs are consumed.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign,
  output logic            illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // classify the op: unknown widths are illegal, halfwords/words need natural alignment
  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    if (we) begin
      illegal = (funct3 > F3_W);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    case (funct3)
      F3_H, F3_HU: misalign = addr_lo[0];
      F3_W:        misalign = (addr_lo != 2'b00);
      default:     misalign = 1'b0;
    endcase
  end

  // stores replicate the datum into every lane and enable only the addressed bytes
  always_comb begin
    be        = 4'hF;
    wdata_rep = wdata;
    if (we) begin
      case (funct3)
        F3_B: begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        F3_H: begin
          be        = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_rep = {2{wdata[15:0]}};
        end
        default: begin
          be        = 4'hF;
          wdata_rep = wdata;
        end
      endcase
    end
  end

  // loads pick the addressed lane out of the returned word and extend it
  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{(XLEN-8){lane_b[7]}}, lane_b};
      F3_H:    rdata_ext = {{(XLEN-16){lane_h[15]}}, lane_h};
      F3_W:    rdata_ext = rdata;
      F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, lane_b};
      F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, lane_h};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Purpose: RV32I load/store unit driving a req/ack word bus; optional bus timeout via LSU_TIMEOUT_EN.
// Latency: accept -> rsp_valid is 3 cycles plus ack wait; 2 cycles for misaligned/illegal ops.
// Backpressure: req_ready only in IDLE; stall holds the core until the response cycle; mem_req held until mem_ack.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t state;

  // request fields kept for the load extension while the bus access is in flight
  logic       cap_we;
  logic [2:0] cap_f3;
  logic [1:0] cap_lo;

  logic            a_we;
  logic [2:0]      a_f3;
  logic [1:0]      a_lo;
  logic [BE_W-1:0] a_be;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] a_rdata;
  logic            a_misalign;
  logic            a_illegal;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_expire;
  assign tmo_expire = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // the aligner sees the live request while idle and the captured one afterwards
  assign a_we = (state == IDLE) ? req_we      : cap_we;
  assign a_f3 = (state == IDLE) ? req_funct3  : cap_f3;
  assign a_lo = (state == IDLE) ? req_addr[1:0] : cap_lo;

  lsu_align #(.XLEN(XLEN)) u_align (
    .we        (a_we),
    .funct3    (a_f3),
    .addr_lo   (a_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata_rep (a_wdata),
    .rdata_ext (a_rdata),
    .misalign  (a_misalign),
    .illegal   (a_illegal)
  );

  // core handshake: only idle accepts, and the pipeline is frozen until the response cycle
  assign req_ready = (state == IDLE);
  assign stall     = ((state == IDLE) && req_valid) || (state == BUS);

  // main FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_we    <= 1'b0;
      cap_f3    <= 3'b000;
      cap_lo    <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            cap_we <= req_we;
            cap_f3 <= req_funct3;
            cap_lo <= req_addr[1:0];
            if (a_illegal || a_misalign) begin
              // bad ops never touch the bus
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= BUS;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wdata <= req_we ? a_wdata : '0;
              mem_be    <= a_be;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        BUS: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= cap_we ? '0 : a_rdata;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_expire) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Purpose: directed self-checking bench for lsu_mem_if (loads, stores, errors, reset, bus wait/timeout).
// Latency: expectations are hand-computed per vector, including accept->response cycle counts.
// Backpressure: bench acts as the bus slave, acking after a per-vector delay.
module tb_lsu_mem_if;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  lsu_mem_if #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one transaction from IDLE to the cycle after its response
  task automatic run_op(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] rdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input int exp_lat);
    int cyc;
    int bus_cyc;
    int lat;
    logic saw_req;
    logic we_s;
    logic [3:0] be_s;
    logic [31:0] addr_s;
    logic [31:0] wd_s;
    saw_req = 1'b0; we_s = 1'b0; be_s = '0; addr_s = '0; wd_s = '0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    chk({nm, ".ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, ".stall_idle"}, {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_wdata = 32'h5A5A5A5A;
    lat = 0; bus_cyc = 0; cyc = 2;
    while (cyc < 40 && lat == 0) begin
      if (mem_req) begin
        if (!saw_req) begin
          we_s = mem_we; be_s = mem_be; addr_s = mem_addr; wd_s = mem_wdata;
          chk({nm, ".stall_bus"}, {31'd0, stall}, 32'd1);
        end
        saw_req = 1'b1;
        if (bus_cyc == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        bus_cyc++;
      end
      if (rsp_valid) begin
        lat = cyc;
        chk({nm, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        chk({nm, ".rdata"}, rsp_rdata, exp_rdata);
        chk({nm, ".stall_resp"}, {31'd0, stall}, 32'd0);
      end
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'h13579BDF;
      if (lat == 0) cyc++;
    end
    chk({nm, ".latency"}, lat, exp_lat);
    chk({nm, ".pulse"}, {31'd0, rsp_valid}, 32'd0);
    chk({nm, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    if (exp_err) begin
      chk({nm, ".no_req"}, {31'd0, saw_req}, 32'd0);
    end else begin
      chk({nm, ".saw_req"}, {31'd0, saw_req}, 32'd1);
      chk({nm, ".we"}, {31'd0, we_s}, {31'd0, we});
      chk({nm, ".addr"}, addr_s, {addr[31:2], 2'b00});
      chk({nm, ".be"}, {28'd0, be_s}, {28'd0, exp_be});
      if (we) chk({nm, ".wdata"}, wd_s, exp_wdata);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int hi_cnt;
    int got_rsp;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    do_reset();

    // reset state
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.stall", {31'd0, stall}, 32'd0);

    // stray ack while idle must not produce a response
    mem_ack = 1'b1;
    got_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid || mem_req) got_rsp++;
    end
    mem_ack = 1'b0;
    chk("idle_ack.ignored", got_rsp, 0);

    //      name   we    f3      addr          wdata         dly rdata         err  exp_rdata     be       exp_wdata     lat
    run_op("sw",   1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 2, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'hF,    32'hDEADBEEF, 5);
    run_op("lb",   1'b0, 3'b000, 32'h00000103, 32'h0,        0, 32'h80123456, 1'b0, 32'hFFFFFF80, 4'hF,    32'h0,        3);
    run_op("lbu",  1'b0, 3'b100, 32'h00000103, 32'h0,        1, 32'h80123456, 1'b0, 32'h00000080, 4'hF,    32'h0,        4);
    run_op("lhu",  1'b0, 3'b101, 32'h00000102, 32'h0,        0, 32'hBEEF0000, 1'b0, 32'h0000BEEF, 4'hF,    32'h0,        3);
    run_op("lh",   1'b0, 3'b001, 32'h00000102, 32'h0,        0, 32'hBEEF0000, 1'b0, 32'hFFFFBEEF, 4'hF,    32'h0,        3);
    run_op("lb0",  1'b0, 3'b000, 32'h00000100, 32'h0,        0, 32'h1234567F, 1'b0, 32'h0000007F, 4'hF,    32'h0,        3);
    run_op("lw",   1'b0, 3'b010, 32'h00000104, 32'h0,        3, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4'hF,    32'h0,        6);
    run_op("sh",   1'b1, 3'b001, 32'h00000102, 32'h00001234, 0, 32'h0,        1'b0, 32'h00000000, 4'b1100, 32'h12341234, 3);
    run_op("sb",   1'b1, 3'b000, 32'h00000101, 32'h000000AB, 0, 32'h0,        1'b0, 32'h00000000, 4'b0010, 32'hABABABAB, 3);
    run_op("sb3",  1'b1, 3'b000, 32'h00000203, 32'h000000C5, 1, 32'h0,        1'b0, 32'h00000000, 4'b1000, 32'hC5C5C5C5, 4);
    run_op("lw_mis", 1'b0, 3'b010, 32'h00000102, 32'h0,      0, 32'h0,        1'b1, 32'h00000000, 4'h0,    32'h0,        2);
    run_op("sh_mis", 1'b1, 3'b001, 32'h00000101, 32'h1234,   0, 32'h0,        1'b1, 32'h00000000, 4'h0,    32'h0,        2);
    run_op("ld_ill", 1'b0, 3'b011, 32'h00000100, 32'h0,      0, 32'h0,        1'b1, 32'h00000000, 4'h0,    32'h0,        2);
    run_op("st_ill", 1'b1, 3'b100, 32'h00000100, 32'h0,      0, 32'h0,        1'b1, 32'h00000000, 4'h0,    32'h0,        2);

    // reset during the second bus cycle, then a late ack
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000200;
    tick();
    req_valid = 1'b0;
    chk("rstbus.req_c1", {31'd0, mem_req}, 32'd1);
    tick();
    chk("rstbus.req_c2", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h11111111;
    tick();
    chk("rstbus.req_drop", {31'd0, mem_req}, 32'd0);
    rst_n = 1'b1;
    got_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || mem_req) got_rsp++;
      tick();
    end
    mem_ack = 1'b0;
    chk("rstbus.no_rsp", got_rsp, 0);
    chk("rstbus.ready", {31'd0, req_ready}, 32'd1);

    // bus slave never acks
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00000300;
    tick();
    req_valid = 1'b0;
    hi_cnt = 0;
    got_rsp = 0;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 20 && got_rsp == 0; i++) begin
      if (mem_req) hi_cnt++;
      if (rsp_valid) begin
        got_rsp = 1;
        chk("tmo.err", {31'd0, rsp_err}, 32'd1);
        chk("tmo.rdata", rsp_rdata, 32'd0);
      end
      tick();
    end
    chk("tmo.req_cycles", hi_cnt, 4);
    chk("tmo.rsp_seen", got_rsp, 1);
`else
    for (int i = 0; i < 1000; i++) begin
      if (mem_req) hi_cnt++;
      if (rsp_valid) got_rsp++;
      tick();
    end
    chk("noack.req_cycles", hi_cnt, 1000);
    chk("noack.no_rsp", got_rsp, 0);
    chk("noack.stall", {31'd0, stall}, 32'd1);
    do_reset();
`endif
    chk("end.ready", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
